fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_next_pc.sv | 32 +++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
// FSM state encoding, controller branch-select codes and the halt opcode.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] BR_SEQ = 2'd0;
    localparam logic [1:0] BR_TGT = 2'd1;
    localparam logic [1:0] BR_RET = 2'd2;

    localparam logic [3:0] OP_HALT = 4'd0;

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection plus the sequential +2 adder.
// Branch and return destinations are forced to halfword alignment.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_lr,
    input  logic [ADDR_W-1:0] i_branchTarget,
    input  logic [1:0]        i_branchSel,
    output logic [ADDR_W-1:0] o_nextPc,
    output logic [ADDR_W-1:0] o_pcPlus2
);

    logic [ADDR_W-1:0] w_pcPlus2;

    // Wraps silently at the top of the address space.
    assign w_pcPlus2 = i_pc + ADDR_W'(2);
    assign o_pcPlus2 = w_pcPlus2;

    // Pick the destination; code 3 behaves as sequential.
    always_comb begin
        o_nextPc = w_pcPlus2;
        case (i_branchSel)
            BR_TGT:  o_nextPc = {i_branchTarget[ADDR_W-1:1], 1'b0};
            BR_RET:  o_nextPc = {i_lr[ADDR_W-1:1], 1'b0};
            default: o_nextPc = w_pcPlus2;
        endcase
    end

endmodule : fetch_next_pc

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with PC and link register.
// FETCH requests from imem, HOLD presents the instruction until retired.
// Optional halt support is enabled by defining FETCH_HALT_EN; op 0 then
// parks the unit in HALT until reset.
// An ack is only accepted once the request has been visible across at least
// one clock edge, so a response belonging to a request aborted by reset can
// never be captured by the restarted fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [1:0]        branch_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              lr_we,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] lr,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:1], 1'b0};

    fetch_state_t      r_state;
    fetch_state_t      w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_lr;
    logic [15:0]       r_instr;
    logic              r_reqIssued;
    logic              w_ackAccept;
    logic              w_retire;
    logic              w_isHalt;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] w_pcPlus2;

    fetch_next_pc #(
        .ADDR_W(ADDR_W)
    ) u_nextPc (
        .i_pc          (r_pc),
        .i_lr          (r_lr),
        .i_branchTarget(branch_target),
        .i_branchSel   (branch_sel),
        .o_nextPc      (w_nextPc),
        .o_pcPlus2     (w_pcPlus2)
    );

    // State register; reset always restarts in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_nextState = r_state;
        w_ackAccept = 1'b0;
        w_retire    = 1'b0;
`ifdef FETCH_HALT_EN
        w_isHalt    = (r_instr[15:12] == OP_HALT);
        halted      = (r_state == ST_HALT);
`else
        w_isHalt    = 1'b0;
        halted      = 1'b0;
`endif
        imem_req    = (r_state == ST_FETCH) && rst_n;
        instr_valid = (r_state == ST_HOLD);
        case (r_state)
            ST_FETCH: begin
                w_ackAccept = imem_ack && r_reqIssued;
                if (w_ackAccept) begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_retire = instr_ready;
                if (instr_ready) begin
                    w_nextState = w_isHalt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase
    end

    // Datapath: instruction capture, PC/LR update on retire, request age flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC_ALIGNED;
            r_lr        <= '0;
            r_instr     <= '0;
            r_reqIssued <= 1'b0;
        end else begin
            r_reqIssued <= (r_state == ST_FETCH) && !w_ackAccept;
            if (w_ackAccept) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc <= w_nextPc;
                if (lr_we) begin
                    r_lr <= w_pcPlus2;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign lr        = r_lr;
    assign instr     = r_instr;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The halt scenario is selected by FETCH_HALT_EN, matching the design build.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  branch_sel;
    logic [15:0] branch_target;
    logic        lr_we;
    logic [15:0] pc;
    logic [15:0] lr;
    logic        halted;

    int total;
    int bad;

    fetch_unit #(
        .ADDR_W  (16),
        .RESET_PC(16'h0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_sel   (branch_sel),
        .branch_target(branch_target),
        .lr_we        (lr_we),
        .pc           (pc),
        .lr           (lr),
        .halted       (halted)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Act as instruction memory: check the request, wait, then ack with data.
    task automatic serveFetch(input logic [15:0] addr, input logic [15:0] data,
                              input int waits);
        checkOutput("req", imem_req, 1);
        checkOutput("addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            checkOutput("addrHeld", imem_addr, addr);
            checkOutput("reqHeld", imem_req, 1);
            checkOutput("noValidYet", instr_valid, 0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'hBEEF;
        checkOutput("valid", instr_valid, 1);
        checkOutput("instr", instr, data);
        checkOutput("pcHeld", pc, addr);
        checkOutput("reqDropped", imem_req, 0);
    endtask

    // Retire the held instruction with the given branch controls.
    task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] target,
                                 input logic lrwe);
        instr_ready   = 1'b1;
        branch_sel    = sel;
        branch_target = target;
        lr_we         = lrwe;
        @(negedge clk);
        instr_ready   = 1'b0;
        branch_sel    = BR_SEQ;
        branch_target = 16'h0000;
        lr_we         = 1'b0;
        checkOutput("retired", instr_valid, 0);
    endtask

    // Directed sequence.
    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        instr_ready   = 1'b0;
        branch_sel    = BR_SEQ;
        branch_target = 16'h0000;
        lr_we         = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("rstReq", imem_req, 0);
        checkOutput("rstAddr", imem_addr, 16'h0000);
        checkOutput("rstPc", pc, 16'h0000);
        checkOutput("rstLr", lr, 16'h0000);
        checkOutput("rstInstr", instr, 16'h0000);
        checkOutput("rstValid", instr_valid, 0);
        checkOutput("rstHalted", halted, 0);

        // First request right after reset release, then sequential fetch.
        rst_n = 1'b1;
        #1;
        checkOutput("firstReq", imem_req, 1);
        serveFetch(16'h0000, 16'h1111, 3);
        applyStimulus(BR_SEQ, 16'h0000, 1'b0);
        serveFetch(16'h0002, 16'h2222, 3);
        applyStimulus(BR_SEQ, 16'h0000, 1'b0);
        serveFetch(16'h0004, 16'h3333, 3);
        applyStimulus(BR_TGT, 16'h0010, 1'b0);

        // Call to an odd target (aligned down) and return.
        serveFetch(16'h0010, 16'h4444, 1);
        applyStimulus(BR_TGT, 16'h0041, 1'b1);
        checkOutput("callLr", lr, 16'h0012);
        serveFetch(16'h0040, 16'h5555, 2);
        applyStimulus(BR_RET, 16'hABCD, 1'b0);
        checkOutput("retLrKept", lr, 16'h0012);
        serveFetch(16'h0012, 16'h6666, 1);

        // Build lr=0x0100, then return and link in the same retire at 0x0020.
        applyStimulus(BR_TGT, 16'h00FE, 1'b0);
        serveFetch(16'h00FE, 16'h7777, 1);
        applyStimulus(BR_TGT, 16'h0020, 1'b1);
        checkOutput("lrSetup", lr, 16'h0100);
        serveFetch(16'h0020, 16'h8888, 1);
        applyStimulus(BR_RET, 16'h0000, 1'b1);
        checkOutput("retLinkLr", lr, 16'h0022);
        serveFetch(16'h0100, 16'h9999, 1);

        // Top of address space with backpressure and a stray ack while holding.
        applyStimulus(BR_TGT, 16'hFFFF, 1'b0);
        serveFetch(16'hFFFE, 16'hA5A5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'h1234;
            end
            @(negedge clk);
            imem_ack = 1'b0;
            checkOutput("bpInstr", instr, 16'hA5A5);
            checkOutput("bpPc", pc, 16'hFFFE);
            checkOutput("bpValid", instr_valid, 1);
            checkOutput("bpNoReq", imem_req, 0);
        end
        applyStimulus(BR_SEQ, 16'h0000, 1'b1);
        checkOutput("wrapLr", lr, 16'h0000);
        serveFetch(16'h0000, 16'hB0B0, 1);
        applyStimulus(2'd3, 16'h0040, 1'b0);

        // Op 0 instruction.
        serveFetch(16'h0002, 16'h0000, 1);
        applyStimulus(BR_SEQ, 16'h0000, 1'b0);
`ifdef FETCH_HALT_EN
        checkOutput("haltFlag", halted, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'h5A5A;
            end
            @(negedge clk);
            imem_ack = 1'b0;
            checkOutput("haltNoReq", imem_req, 0);
            checkOutput("haltStays", halted, 1);
            checkOutput("haltNoValid", instr_valid, 0);
        end
`else
        checkOutput("noHaltFlag", halted, 0);
        checkOutput("op0Req", imem_req, 1);
        checkOutput("op0Addr", imem_addr, 16'h0004);
`endif

        // Reset abort with a stale ack in the first cycle after release.
        rst_n = 1'b0;
        #1;
        checkOutput("rst2Req", imem_req, 0);
        checkOutput("rst2Pc", pc, 16'h0000);
        checkOutput("rst2Halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("preAbortReq", imem_req, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortReqDrop", imem_req, 0);
        checkOutput("abortAddr", imem_addr, 16'h0000);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        checkOutput("staleNoValid", instr_valid, 0);
        checkOutput("staleInstr", instr, 16'h0000);
        checkOutput("restartReq", imem_req, 1);
        checkOutput("restartAddr", imem_addr, 16'h0000);
        serveFetch(16'h0000, 16'hC3C3, 1);
        applyStimulus(BR_SEQ, 16'h0000, 1'b0);
        checkOutput("afterAbortAddr", imem_addr, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
